// File: rtl/tail_light_pkg.sv
// Shared mode encoding, parameter legality limits and request priority for the tail-light sequencer.
// Combinational helpers only; no latency and no backpressure.
package tail_light_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    localparam int LAMPS_MIN       = 1;
    localparam int LAMPS_MAX       = 8;
    localparam int STEP_CYCLES_MIN = 1;
    localparam int STEP_CYCLES_MAX = 65536;
    localparam int DIM_BITS_MIN    = 1;
    localparam int DIM_BITS_MAX    = 8;

    // Hazard wins, and both turn stalks at once are treated as hazard.
    function automatic mode_t req_mode(input logic left, input logic right, input logic hazard);
        if (hazard || (left && right)) return HAZARD;
        if (left)                      return LEFT;
        if (right)                     return RIGHT;
        return IDLE;
    endfunction

endpackage

// File: rtl/tail_light_dimmer.sv
// Free-running PWM counter with duty compare; dim_on follows the counter combinationally.
// No backpressure; dim_duty=0 never lights, the full period is 2^DIM_BITS cycles.
module tail_light_dimmer #(
    parameter int DIM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DIM_BITS-1:0] dim_duty,
    output logic                dim_on
);

    logic [DIM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clock) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + DIM_BITS'(1);
    end

    assign dim_on = (pwm_cnt < dim_duty);

endmodule

// File: rtl/tail_light_sequencer.sv
// Turn/hazard/brake tail-light animator with PWM running-light fill on unlit lamps.
// Two-edge latency from request inputs to out; no backpressure, inputs are levels.
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 4,
    parameter int DIM_BITS    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                left,
    input  logic                right,
    input  logic                hazard,
    input  logic                brake,
    input  logic                lights,
    input  logic [DIM_BITS-1:0] dim_duty,
    output logic [2*LAMPS-1:0]  out
);

    localparam int OUT_W  = 2 * LAMPS;
    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam int PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    if (LAMPS < LAMPS_MIN || LAMPS > LAMPS_MAX) begin : g_bad_lamps
        $error("tail_light_sequencer: LAMPS out of range");
    end
    if (STEP_CYCLES < STEP_CYCLES_MIN || STEP_CYCLES > STEP_CYCLES_MAX) begin : g_bad_step
        $error("tail_light_sequencer: STEP_CYCLES out of range");
    end
    if (DIM_BITS < DIM_BITS_MIN || DIM_BITS > DIM_BITS_MAX) begin : g_bad_dim
        $error("tail_light_sequencer: DIM_BITS out of range");
    end

    mode_t              mode, mode_nxt, req;
    logic [STEP_W-1:0]  step, step_nxt;
    logic [PRE_W-1:0]   pre, pre_nxt;
    logic               brake_q, lights_q;
    logic               dim_on;
    logic [LAMPS-1:0]   depth_lit, left_lit, right_lit;
    logic [OUT_W-1:0]   out_nxt;

    tail_light_dimmer #(.DIM_BITS(DIM_BITS)) u_dimmer (
        .clock    (clock),
        .reset    (reset),
        .dim_duty (dim_duty),
        .dim_on   (dim_on)
    );

    // brake/lights are staged alongside mode so every input sees the same two-edge latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode     <= IDLE;
            step     <= '0;
            pre      <= '0;
            brake_q  <= 1'b0;
            lights_q <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            step     <= step_nxt;
            pre      <= pre_nxt;
            brake_q  <= brake;
            lights_q <= lights;
        end
    end

    always_comb begin
        req      = req_mode(left, right, hazard);
        mode_nxt = mode;
        step_nxt = step;
        pre_nxt  = pre;
        if (req != mode) begin
            mode_nxt = req;
            step_nxt = (req == IDLE) ? '0 : STEP_W'(1);
            pre_nxt  = '0;
        end else if (mode == IDLE) begin
            step_nxt = '0;
            pre_nxt  = '0;
        end else if (pre == PRE_W'(STEP_CYCLES - 1)) begin
            pre_nxt = '0;
            if (mode == HAZARD)
                step_nxt = (step == '0) ? STEP_W'(1) : '0;
            else
                step_nxt = (step == STEP_W'(LAMPS)) ? '0 : step + STEP_W'(1);
        end else begin
            pre_nxt = pre + PRE_W'(1);
        end
    end

    // depth_lit[i] is the lamp i positions out from the centre on the turning side.
    always_comb begin
        depth_lit = '0;
        right_lit = '0;
        left_lit  = '0;
        for (int i = 0; i < LAMPS; i++) begin
            depth_lit[i] = (int'(step) > i);
        end
        case (mode)
            LEFT: begin
                left_lit  = depth_lit;
                right_lit = {LAMPS{brake_q}};
            end
            RIGHT: begin
                for (int i = 0; i < LAMPS; i++) right_lit[LAMPS-1-i] = depth_lit[i];
                left_lit = {LAMPS{brake_q}};
            end
            HAZARD: begin
                left_lit  = {LAMPS{step == STEP_W'(1)}};
                right_lit = {LAMPS{step == STEP_W'(1)}};
            end
            default: begin
                left_lit  = {LAMPS{brake_q}};
                right_lit = {LAMPS{brake_q}};
            end
        endcase
        out_nxt = {left_lit, right_lit} | {OUT_W{lights_q & dim_on}};
    end

    always_ff @(posedge clock) begin
        if (reset) out <= '0;
        else       out <= out_nxt;
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with a lamp-level reference model checked every cycle.
module tb_tail_light_sequencer;

    localparam int L    = 3;
    localparam int SC   = 2;
    localparam int DB   = 4;
    localparam int NOUT = 2 * L;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0, lights = 1'b0;
    logic [DB-1:0]   dim_duty = '0;
    logic [NOUT-1:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    tail_light_sequencer #(.LAMPS(L), .STEP_CYCLES(SC), .DIM_BITS(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .left     (left),
        .right    (right),
        .hazard   (hazard),
        .brake    (brake),
        .lights   (lights),
        .dim_duty (dim_duty),
        .out      (out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [NOUT-1:0] got, input logic [NOUT-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: out=%b required=%b at %0t", name, got, exp, $time);
    endtask

    // Reference model: 0 idle, 1 left, 2 right, 3 hazard; lamps evaluated one by one.
    int              m_mode = 0, m_step = 0, m_pre = 0, m_pwm = 0;
    bit              m_brake = 0, m_lights = 0, model_valid = 0;
    logic [NOUT-1:0] m_out = '0;

    function automatic bit lamp_lit(int i, int mode, int stp, bit brk, bit lts, bit dim);
        int  side  = (i >= L) ? 1 : 2;
        int  depth = (i >= L) ? (i - L) : (L - 1 - i);
        bit  on    = 0;
        if (mode == 3)         on = (stp == 1);
        else if (mode == side) on = (depth < stp);
        else                   on = brk;
        return on | (lts & dim);
    endfunction

    always @(posedge clock) begin
        logic [NOUT-1:0] nxt;
        int req;
        for (int i = 0; i < NOUT; i++)
            nxt[i] = lamp_lit(i, m_mode, m_step, m_brake, m_lights, m_pwm < int'(dim_duty));
        if (reset) begin
            m_mode = 0; m_step = 0; m_pre = 0; m_pwm = 0;
            m_brake = 0; m_lights = 0; m_out = '0;
        end else begin
            m_out = nxt;
            req = (hazard || (left && right)) ? 3 : left ? 1 : right ? 2 : 0;
            if (req != m_mode) begin
                m_mode = req; m_step = (req == 0) ? 0 : 1; m_pre = 0;
            end else if (m_mode == 0) begin
                m_step = 0; m_pre = 0;
            end else if (m_pre == SC - 1) begin
                m_pre  = 0;
                m_step = (m_mode == 3) ? (1 - m_step) : ((m_step + 1) % (L + 1));
            end else begin
                m_pre++;
            end
            m_pwm    = (m_pwm + 1) % (1 << DB);
            m_brake  = brake;
            m_lights = lights;
        end
        model_valid = 1;
    end

    always @(negedge clock) begin
        if (model_valid) check("model", out, m_out);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; left = 0; right = 0; hazard = 0; brake = 0; lights = 0; dim_duty = '0;
        tick(3);
        check("reset_out", out, '0);
    endtask

    typedef struct {
        logic l, r, h, b, lt;
        logic [DB-1:0] duty;
        int cycles;
    } vec_t;

    logic [NOUT-1:0] seq_left[9]  = '{6'b001000, 6'b001000, 6'b011000, 6'b011000, 6'b111000,
                                      6'b111000, 6'b000000, 6'b000000, 6'b001000};
    logic [NOUT-1:0] seq_haz[6]   = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b111111, 6'b111111};
    logic [NOUT-1:0] seq_rbrk[8]  = '{6'b111100, 6'b111100, 6'b111110, 6'b111110, 6'b111111,
                                      6'b111111, 6'b111000, 6'b111000};
    vec_t vecs[6] = '{
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  6},
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8,  20},
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  12},
        '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 10},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  18},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  5}
    };

    initial begin
        int ones, mixed;

        // Left animation from reset, including the two-edge first latency.
        do_reset();
        reset = 1'b0; left = 1'b1;
        tick(1);
        check("left_latency", out, 6'b000000);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            check("left_seq", out, seq_left[i]);
        end

        // Hazard, then both stalks giving the same response.
        do_reset();
        reset = 1'b0; hazard = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("hazard_seq", out, seq_haz[i]);
        end
        do_reset();
        reset = 1'b0; left = 1'b1; right = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("both_seq", out, seq_haz[i]);
        end

        // Right turn with brake holding the left side on.
        do_reset();
        reset = 1'b0; right = 1'b1; brake = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("right_brake_seq", out, seq_rbrk[i]);
        end

        // Switch left->right while left sits at step 2.
        do_reset();
        reset = 1'b0; left = 1'b1;
        tick(3);
        left = 1'b0; right = 1'b1;
        tick(1);
        check("switch_prev", out, 6'b011000);
        tick(1);
        check("switch_right", out, 6'b000100);

        // Idle running lights at duty 4/16, then duty 0.
        do_reset();
        reset = 1'b0; lights = 1'b1; dim_duty = 4'd4;
        tick(3);
        ones = 0; mixed = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (out == 6'b111111) ones++;
            else if (out != 6'b000000) mixed++;
        end
        check("dim_on_count", 6'(ones), 6'd8);
        check("dim_in_phase", 6'(mixed), 6'd0);
        dim_duty = 4'd0;
        tick(2);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (out != 6'b000000) ones++;
        end
        check("dim_zero", 6'(ones), 6'd0);

        // Reset mid-hazard while fully lit, then restart at step 1.
        do_reset();
        reset = 1'b0; hazard = 1'b1;
        tick(2);
        check("pre_reset_lit", out, 6'b111111);
        reset = 1'b1;
        tick(1);
        check("reset_mid_hazard", out, 6'b000000);
        tick(2);
        check("reset_held", out, 6'b000000);
        reset = 1'b0;
        tick(1);
        check("restart_latency", out, 6'b000000);
        tick(1);
        check("restart_step1", out, 6'b111111);

        // Mixed directed vectors checked against the model only.
        do_reset();
        reset = 1'b0;
        for (int v = 0; v < 6; v++) begin
            left = vecs[v].l; right = vecs[v].r; hazard = vecs[v].h;
            brake = vecs[v].b; lights = vecs[v].lt; dim_duty = vecs[v].duty;
            tick(vecs[v].cycles);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tail_light_sequencer.md
TAIL_LIGHT_SEQUENCER -- requirements
Module: tail_light_sequencer

Interface
REQ-001 Parameter LAMPS, default 3, SHALL set the lamp count per side (range 1..8).
REQ-002 Parameter STEP_CYCLES, default 4, SHALL set the clock cycles per animation step (range 1..2^16).
REQ-003 Parameter DIM_BITS, default 4, SHALL set the dimming PWM counter width (range 1..8).
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 left  in  1  left-turn request, level.
REQ-007 right  in  1  right-turn request, level.
REQ-008 hazard  in  1  hazard request, level.
REQ-009 brake  in  1  brake request, level.
REQ-010 lights  in  1  running-lights enable, level.
REQ-011 dim_duty  in  DIM_BITS  running-light duty; a lamp is lit for dim_duty of every 2^DIM_BITS cycles.
REQ-012 out  out  2*LAMPS  registered lamp drives; out[LAMPS-1:0] right side with out[LAMPS-1] innermost; out[2*LAMPS-1:LAMPS] left side with out[LAMPS] innermost.

Function
REQ-013 Requested mode SHALL be: HAZARD if hazard or (left and right); else LEFT if left; else RIGHT if right; else IDLE.
REQ-014 The FSM SHALL hold mode (IDLE/LEFT/RIGHT/HAZARD), step (0..LAMPS), and prescaler pre (0..STEP_CYCLES-1).
REQ-015 When the requested mode differs from the current mode, the FSM SHALL load the requested mode, set step=1, and clear pre on that edge.
REQ-016 Otherwise pre SHALL increment, and on pre==STEP_CYCLES-1 it SHALL wrap to 0 and advance step.
REQ-017 In LEFT/RIGHT, step advance SHALL be 1->2->...->LAMPS->0->1 (wrap-around); step k lights the k innermost lamps of the turning side; step 0 lights none.
REQ-018 In HAZARD, step SHALL alternate 1<->0; step 1 lights all 2*LAMPS lamps and step 0 lights none.
REQ-019 In IDLE, step and pre SHALL be held at 0.
REQ-020 Brake SHALL drive every lamp not under turn control fully on: in IDLE the whole array; in LEFT/RIGHT the non-turning side; in HAZARD brake SHALL have no effect.
REQ-021 A free-running DIM_BITS PWM counter SHALL produce dim_on = (pwm_cnt < dim_duty); dim_duty=0 gives never on.
REQ-022 A lamp not lit by REQ-017, REQ-018 or REQ-020 SHALL be driven with dim_on when lights=1, and with 0 when lights=0; this includes the unlit lamps of an animating side.
REQ-023 out SHALL be registered from the current mode, step, brake, lights and dim_on; inputs sampled at edge t appear on out after edge t+1 (2-edge latency).

Reset
REQ-024 On reset=1 at a clock edge: mode=IDLE, step=0, pre=0, pwm_cnt=0, out=0, overriding all inputs, including mid-animation.
REQ-025 The first edge after reset deasserts SHALL behave as REQ-015 when the request is non-IDLE.

Structure
REQ-026 Package tail_light_pkg SHALL hold the mode enum (IDLE, LEFT, RIGHT, HAZARD) and the parameter-legality constants.
REQ-027 PWM counter and compare SHALL live in one sub-module, tail_light_dimmer (inputs clock, reset, dim_duty; output dim_on).
REQ-028 Illegal parameter values SHALL stop elaboration with an error.

Verification (LAMPS=3, STEP_CYCLES=2, DIM_BITS=4, lights=0 unless stated; out shown [5:0])
REQ-029 Left held from reset -> out cycles 001000, 011000, 111000, 000000, each lasting 2 cycles, first value 2 edges after left rises.
REQ-030 Hazard held -> 111111 for 2 cycles, then 000000 for 2 cycles, repeating; left=right=1 gives the same response.
REQ-031 Right and brake held -> left side stays 111; right side cycles 100, 110, 111, 000.
REQ-032 IDLE, lights=1, dim_duty=4 -> every lamp high for exactly 4 of every 16 cycles, in phase across lamps; dim_duty=0 -> out=0.
REQ-033 Left at step 2, then switch to right -> next edge: mode RIGHT, step 1; out becomes 000100; left side dark.
REQ-034 Reset asserted mid-hazard while out=111111 -> out=000000 after that edge and through reset; animation restarts at step 1 after release.
